// File: rtl/filter_top_level_if.sv
// filter_top_level_if
//   Pixel-in / pixel-out bundle for the colour filter stage.
//   in              : 32-bit pixel word {b3,b2,b1,b0}
//   filterMode      : 00 debayer, 01 brighten, 10 darken, 11 grayscale
//   brightnessCoeff : unsigned brightness offset (beta)
//   result          : filtered pixel {alpha,R,G,B}
//   master drives the pixel and controls; slave (the filter) drives result.
interface filter_top_level_if;
  logic [31:0] in;
  logic [1:0]  filterMode;
  logic [7:0]  brightnessCoeff;
  logic [31:0] result;

  modport master (output in, output filterMode, output brightnessCoeff, input result);
  modport slave  (input in, input filterMode, input brightnessCoeff, output result);
endinterface

// File: rtl/filter_top_level.sv
// filter_top_level
//   Per-pixel colour filter, purely combinational.
//   Ports:
//     clk   : system clock, kept for pipeline-interface uniformity only
//     n_rst : async active-low reset, kept for uniformity only
//     bus   : filter_top_level_if.slave (in, filterMode, brightnessCoeff -> result)
//   result = {8'hFF, R, G, B}; the RGB source depends on filterMode.

// One colour channel's saturating add/subtract of beta.
module filter_lane (
  input  logic [7:0] ch_i,
  input  logic [7:0] beta_i,
  output logic [7:0] add_sat_o,
  output logic [7:0] sub_sat_o
);
  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, ch_i} + {1'b0, beta_i};
  assign diff = {1'b0, ch_i} - {1'b0, beta_i};

  // Bit 8 is carry-out on the add and borrow on the subtract.
  assign add_sat_o = sum[8]  ? 8'hFF : sum[7:0];
  assign sub_sat_o = diff[8] ? 8'h00 : diff[7:0];
endmodule

module filter_top_level (
  input  logic                 clk,
  input  logic                 n_rst,
  filter_top_level_if.slave    bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {
    MODE_DEBAYER = 2'b00,
    MODE_BRIGHT  = 2'b01,
    MODE_DARK    = 2'b10,
    MODE_GRAY    = 2'b11
  } mode_e;

  // clk/n_rst intentionally have no effect on the datapath.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, n_rst};

  mode_e mode;
  assign mode = mode_e'(bus.filterMode);

  // xRGB view: lane 2 = R (b2), lane 1 = G (b1), lane 0 = B (b0).
  logic [NUM_LANES-1:0][VEC_W-1:0] ch;
  logic [NUM_LANES-1:0][VEC_W-1:0] add_sat;
  logic [NUM_LANES-1:0][VEC_W-1:0] sub_sat;

  assign ch = bus.in[NUM_LANES*VEC_W-1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    filter_lane u_lane (
      .ch_i      (ch[l]),
      .beta_i    (bus.brightnessCoeff),
      .add_sat_o (add_sat[l]),
      .sub_sat_o (sub_sat[l])
    );
  end

  // Debayer: average the two greens with a 9-bit sum so nothing is lost.
  logic [8:0] g_sum;
  assign g_sum = {1'b0, bus.in[23:16]} + {1'b0, bus.in[15:8]};

  // Grayscale: R + 2G + B fits in 10 bits; /4 is at most 255.
  logic [9:0] y_sum;
  logic [7:0] y;
  assign y_sum = {2'b00, ch[2]} + {1'b0, ch[1], 1'b0} + {2'b00, ch[0]};
  assign y     = y_sum[9:2];

  logic [23:0] rgb;

  always_comb begin
    rgb = 24'h000000;
    unique case (mode)
      MODE_DEBAYER: rgb = {bus.in[31:24], g_sum[8:1], bus.in[7:0]};
      MODE_BRIGHT:  rgb = add_sat;
      MODE_DARK:    rgb = sub_sat;
      MODE_GRAY:    rgb = {y, y, y};
      default:      rgb = 24'h000000;
    endcase
  end

  assign bus.result = {8'hFF, rgb};
endmodule

// File: tb/tb_filter_top_level.sv
module tb_filter_top_level;
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic n_rst;
  bit   clk_en;
  int   checks;
  int   errors;
  sb_t  sb[$];
  event sample_ev;

  filter_top_level_if bus ();

  filter_top_level dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Monitor: result is presented 2 ns after every stimulus change.
  initial begin
    sb_t e;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL %s: result=%h but no expected value queued", "orphan", bus.result);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.result !== e.exp) begin
          errors++;
          $display("FAIL %s: result=%h expected=%h", e.name, bus.result, e.exp);
        end
      end
    end
  end

  task automatic apply(input string name, input logic [1:0] mode,
                       input logic [7:0] beta, input logic [31:0] pix,
                       input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    bus.filterMode      = mode;
    bus.brightnessCoeff = beta;
    bus.in              = pix;
    #2;
    -> sample_ev;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b1;
    n_rst  = 1'b0;
    bus.in = 32'h0;
    bus.filterMode = 2'b00;
    bus.brightnessCoeff = 8'h00;
    #1;
    // Reset held: output is still the pure function of the inputs.
    apply("rst_zero",    2'b00, 8'h00, 32'h00000000, 32'hFF000000);
    #7;
    n_rst = 1'b1;
    #4;

    apply("deb_basic",   2'b00, 8'h00, 32'h21343612, 32'hFF213512);
    apply("deb_floor",   2'b00, 8'h00, 32'h34F9F0FF, 32'hFF34F4FF);
    apply("br_zero",     2'b01, 8'h09, 32'h00000000, 32'hFF090909);
    apply("br_sat",      2'b01, 8'h09, 32'hFAFA00FA, 32'hFFFF09FF);
    apply("br_edge",     2'b01, 8'h09, 32'h00F6F5F7, 32'hFFFFFEFF);
    apply("br_beta0",    2'b01, 8'h00, 32'hAB123456, 32'hFF123456);
    apply("br_beta255",  2'b01, 8'hFF, 32'h00010203, 32'hFFFFFFFF);
    apply("dk_borrow",   2'b10, 8'h09, 32'h00FA0305, 32'hFFF10000);
    apply("dk_beta0",    2'b10, 8'h00, 32'h00FA0305, 32'hFFFA0305);
    apply("dk_edge",     2'b10, 8'h09, 32'h00090A08, 32'hFF000100);
    apply("gray_basic",  2'b11, 8'h00, 32'h00102030, 32'hFF202020);
    apply("gray_max",    2'b11, 8'h00, 32'h00FFFFFF, 32'hFFFFFFFF);
    apply("gray_floor",  2'b11, 8'h00, 32'h00010100, 32'hFF000000);

    // Mode switching with the pixel held.
    apply("sw_deb",      2'b00, 8'h09, 32'h21343612, 32'hFF213512);
    apply("sw_br",       2'b01, 8'h09, 32'h21343612, 32'hFF3D3F1B);
    apply("sw_dk",       2'b10, 8'h09, 32'h21343612, 32'hFF2B2D09);
    apply("sw_gray",     2'b11, 8'h09, 32'h21343612, 32'hFF2C2C2C);

    // Reset asserted/toggled/unknown, clock running then stopped.
    n_rst = 1'b0;
    apply("rst_lo_deb",  2'b00, 8'h09, 32'h21343612, 32'hFF213512);
    n_rst = 1'b1;
    #1;
    n_rst = 1'b0;
    apply("rst_tg_br",   2'b01, 8'h09, 32'h21343612, 32'hFF3D3F1B);
    clk_en = 1'b0;
    #12;
    n_rst = 1'bx;
    apply("rst_x_dk",    2'b10, 8'h09, 32'h21343612, 32'hFF2B2D09);
    n_rst = 1'b0;
    apply("clkoff_gray", 2'b11, 8'h09, 32'h21343612, 32'hFF2C2C2C);
    clk_en = 1'b1;
    n_rst = 1'b1;
    #4;

    // Every queued expectation must have been consumed.
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
